// File: rtl/mem_split_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_split_unit
// Description : MEM-stage splitter. A halfword or word access that crosses a
//               32-bit boundary becomes two RAM accesses, and the two load
//               halves are merged before DataExt.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_split_unit #(
   parameter int SPLIT_EN = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemReqM,
   input  logic             MemWriteM,
   input  logic [1:0]       SizeM,
   input  logic [31:0]      AddrM,
   input  logic [31:0]      StoreDataM,
   output logic [31:0]      A,
   output logic [31:0]      WD,
   output logic [3:0]       WE,
   input  logic [31:0]      RD,
   output logic [31:0]      LoadDataW,
   output logic             StallM,
   output logic             BubbleW,
   output logic             MisalignExcM,
   output logic [CNT_W-1:0] SplitCount
);

   localparam bit c_SPLIT = (SPLIT_EN != 0);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_t;

   state_t r_state, w_next_state;

   logic [31:0]      r_addr;
   logic [31:0]      r_data;
   logic [2:0]       r_m;
   logic             r_write;
   logic             r_word;
   logic             r_merge_pend;
   logic [1:0]       r_merge_k;
   logic             r_merge_word;
   logic [31:0]      r_lo_hold;
   logic [CNT_W-1:0] r_split_count;

   logic [1:0]  w_off;
   logic        w_is_word;
   logic        w_is_half;
   logic [2:0]  w_nbytes;
   logic [2:0]  w_k;
   logic [2:0]  w_m;
   logic        w_cross;
   logic [1:0]  w_sec_k;
   logic [31:0] w_merged;

   function automatic logic [3:0] f_mask(input logic [2:0] nb);
      case (nb)
         3'd0:    return 4'b0000;
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0011;
         3'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   assign w_off     = AddrM[1:0];
   assign w_is_word = SizeM[1];
   assign w_is_half = (SizeM == 2'b01);
   assign w_nbytes  = w_is_word ? 3'd4 : (w_is_half ? 3'd2 : 3'd1);
   assign w_k       = 3'd4 - {1'b0, w_off};
   assign w_m       = w_nbytes - w_k;
   assign w_cross   = MemReqM & ((w_is_half & (w_off == 2'b11)) |
                                 (w_is_word & (w_off != 2'b00)));

   // First-part byte count of the latched access; never 4 once a split is open
   assign w_sec_k   = 2'd0 - r_addr[1:0];

   always_comb begin
      w_merged = (RD << {r_merge_k, 3'b000}) | r_lo_hold;
      if (!r_merge_word) begin
         w_merged[31:16] = 16'h0000;
      end
   end

   assign LoadDataW  = r_merge_pend ? w_merged : RD;
   assign SplitCount = r_split_count;

   // Outputs are gated by rst_n so a request held during reset never reaches the RAM
   always_comb begin
      w_next_state = r_state;
      A            = AddrM;
      WD           = StoreDataM;
      WE           = 4'b0000;
      StallM       = 1'b0;
      BubbleW      = 1'b0;
      MisalignExcM = 1'b0;
      if (!rst_n) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cross) begin
                  if (c_SPLIT) begin
                     WE           = MemWriteM ? f_mask(w_k) : 4'b0000;
                     StallM       = 1'b1;
                     BubbleW      = 1'b1;
                     w_next_state = SECOND;
                  end else begin
                     MisalignExcM = 1'b1;
                  end
               end else if (MemReqM && MemWriteM) begin
                  WE = f_mask(w_nbytes);
               end
            end
            SECOND: begin
               A            = {r_addr[31:2] + 30'd1, 2'b00};
               WD           = r_data >> {w_sec_k, 3'b000};
               WE           = r_write ? f_mask(r_m) : 4'b0000;
               w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_addr        <= 32'h0;
         r_data        <= 32'h0;
         r_m           <= 3'd0;
         r_write       <= 1'b0;
         r_word        <= 1'b0;
         r_merge_pend  <= 1'b0;
         r_merge_k     <= 2'd0;
         r_merge_word  <= 1'b0;
         r_lo_hold     <= 32'h0;
         r_split_count <= '0;
      end else begin
         r_state      <= w_next_state;
         r_merge_pend <= 1'b0;
         if ((r_state == IDLE) && w_cross && c_SPLIT) begin
            r_addr  <= AddrM;
            r_data  <= StoreDataM;
            r_m     <= w_m;
            r_write <= MemWriteM;
            r_word  <= w_is_word;
         end
         if (r_state == SECOND) begin
            r_split_count <= r_split_count + CNT_W'(1);
            if (!r_write) begin
               // RD carries the first word now; the second word arrives next cycle
               r_lo_hold    <= RD >> {r_addr[1:0], 3'b000};
               r_merge_pend <= 1'b1;
               r_merge_k    <= w_sec_k;
               r_merge_word <= r_word;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_split_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_split_unit
// Description : Directed bench for mem_split_unit with a byte-lane RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_split_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        MemReqM, MemWriteM;
   logic [1:0]  SizeM;
   logic [31:0] AddrM, StoreDataM;
   logic [31:0] A, WD, RD, LoadDataW, SplitCount;
   logic [3:0]  WE;
   logic        StallM, BubbleW, MisalignExcM;

   logic        req0, wr0;
   logic [1:0]  size0;
   logic [31:0] addr0, data0;
   logic [31:0] a0, wd0, ld0, cnt0;
   logic [3:0]  we0;
   logic        stall0, bub0, mis0;

   logic [31:0] mem [0:63];
   logic        mem_clr = 1'b0;
   logic        poke_en = 1'b0;
   logic [5:0]  poke_idx = 6'd0;
   logic [31:0] poke_val = 32'h0;

   int checks   = 0;
   int failures = 0;

   mem_split_unit #(.SPLIT_EN(1), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
      .SizeM(SizeM), .AddrM(AddrM), .StoreDataM(StoreDataM), .A(A), .WD(WD),
      .WE(WE), .RD(RD), .LoadDataW(LoadDataW), .StallM(StallM),
      .BubbleW(BubbleW), .MisalignExcM(MisalignExcM), .SplitCount(SplitCount)
   );

   mem_split_unit #(.SPLIT_EN(0), .CNT_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .MemReqM(req0), .MemWriteM(wr0),
      .SizeM(size0), .AddrM(addr0), .StoreDataM(data0), .A(a0), .WD(wd0),
      .WE(we0), .RD(RD), .LoadDataW(ld0), .StallM(stall0),
      .BubbleW(bub0), .MisalignExcM(mis0), .SplitCount(cnt0)
   );

   // RAM: write data and enables are right-aligned, shifted here by A[1:0]
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (poke_en) begin
         mem[poke_idx] <= poke_val;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (WE[b] && ((b + int'(A[1:0])) < 4))
               mem[A[7:2]][8*(b + int'(A[1:0])) +: 8] <= WD[8*b +: 8];
         end
      end
      RD <= mem[A[7:2]];
   end

   task automatic drive(input logic req, input logic wr, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [31:0] dt);
      MemReqM = req; MemWriteM = wr; SizeM = sz; AddrM = ad; StoreDataM = dt;
   endtask

   task automatic clear_mem();
      @(negedge clk); drive(0, 0, 2'b00, 32'h0, 32'h0); mem_clr = 1'b1;
      @(negedge clk); mem_clr = 1'b0;
   endtask

   task automatic poke(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk); drive(0, 0, 2'b00, 32'h0, 32'h0);
      poke_en = 1'b1; poke_idx = idx; poke_val = val;
      @(negedge clk); poke_en = 1'b0;
   endtask

   task automatic test_reset();
      drive(1, 1, 2'b10, 32'h21, 32'h11223344);
      req0 = 1'b1; wr0 = 1'b0; size0 = 2'b10; addr0 = 32'h01; data0 = 32'h0;
      #1 rst_n = 1'b0; mem_clr = 1'b1;
      @(negedge clk); #1;
      checks++; if (WE !== 4'b0000) begin failures++; $display("FAIL rst_we actual=%b required=0000", WE); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_stall actual=%b required=0", StallM); end
      checks++; if (BubbleW !== 1'b0) begin failures++; $display("FAIL rst_bubble actual=%b required=0", BubbleW); end
      checks++; if (A !== 32'h21) begin failures++; $display("FAIL rst_addr actual=%h required=00000021", A); end
      checks++; if (SplitCount !== 32'h0) begin failures++; $display("FAIL rst_count actual=%0d required=0", SplitCount); end
      checks++; if (mis0 !== 1'b0) begin failures++; $display("FAIL rst_misalign actual=%b required=0", mis0); end
      @(negedge clk); rst_n = 1'b1; mem_clr = 1'b0; req0 = 1'b0;
      drive(0, 0, 2'b00, 32'h0, 32'h0);
   endtask

   task automatic test_aligned();
      @(negedge clk); drive(1, 1, 2'b10, 32'h10, 32'hAABBCCDD); #1;
      checks++; if (A !== 32'h10) begin failures++; $display("FAIL al_sw_addr actual=%h required=00000010", A); end
      checks++; if (WE !== 4'b1111) begin failures++; $display("FAIL al_sw_we actual=%b required=1111", WE); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL al_sw_stall actual=%b required=0", StallM); end
      checks++; if (WD !== 32'hAABBCCDD) begin failures++; $display("FAIL al_sw_wd actual=%h required=aabbccdd", WD); end
      @(negedge clk); drive(1, 1, 2'b00, 32'h13, 32'h0000005A); #1;
      checks++; if (WE !== 4'b0001) begin failures++; $display("FAIL al_sb_we actual=%b required=0001", WE); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL al_sb_stall actual=%b required=0", StallM); end
      @(negedge clk); drive(1, 1, 2'b01, 32'h32, 32'h00001234); #1;
      checks++; if (WE !== 4'b0011) begin failures++; $display("FAIL al_sh32_we actual=%b required=0011", WE); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL al_sh32_stall actual=%b required=0", StallM); end
      @(negedge clk); drive(1, 0, 2'b10, 32'h10, 32'h0); #1;
      checks++; if (WE !== 4'b0000) begin failures++; $display("FAIL al_lw_we actual=%b required=0000", WE); end
      @(negedge clk); drive(0, 0, 2'b00, 32'h10, 32'h0); #1;
      checks++; if (mem[4] !== 32'h5ABBCCDD) begin failures++; $display("FAIL al_mem_word4 actual=%h required=5abbccdd", mem[4]); end
      checks++; if (LoadDataW !== 32'h5ABBCCDD) begin failures++; $display("FAIL al_lw_data actual=%h required=5abbccdd", LoadDataW); end
      checks++; if (mem[12] !== 32'h12340000) begin failures++; $display("FAIL al_mem_word12 actual=%h required=12340000", mem[12]); end
   endtask

   task automatic test_split_store_word();
      clear_mem();
      @(negedge clk); drive(1, 1, 2'b10, 32'h21, 32'h11223344); #1;
      checks++; if (A !== 32'h21) begin failures++; $display("FAIL ssw_a0 actual=%h required=00000021", A); end
      checks++; if (WE !== 4'b0111) begin failures++; $display("FAIL ssw_we0 actual=%b required=0111", WE); end
      checks++; if (WD !== 32'h11223344) begin failures++; $display("FAIL ssw_wd0 actual=%h required=11223344", WD); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL ssw_stall0 actual=%b required=1", StallM); end
      checks++; if (BubbleW !== 1'b1) begin failures++; $display("FAIL ssw_bubble0 actual=%b required=1", BubbleW); end
      checks++; if (MisalignExcM !== 1'b0) begin failures++; $display("FAIL ssw_misalign actual=%b required=0", MisalignExcM); end
      @(negedge clk); #1;
      checks++; if (A !== 32'h24) begin failures++; $display("FAIL ssw_a1 actual=%h required=00000024", A); end
      checks++; if (WE !== 4'b0001) begin failures++; $display("FAIL ssw_we1 actual=%b required=0001", WE); end
      checks++; if (WD !== 32'h11) begin failures++; $display("FAIL ssw_wd1 actual=%h required=00000011", WD); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL ssw_stall1 actual=%b required=0", StallM); end
      @(negedge clk); drive(0, 0, 2'b00, 32'h0, 32'h0); #1;
      checks++; if (mem[8] !== 32'h22334400) begin failures++; $display("FAIL ssw_word20 actual=%h required=22334400", mem[8]); end
      checks++; if (mem[9] !== 32'h00000011) begin failures++; $display("FAIL ssw_word24 actual=%h required=00000011", mem[9]); end
      checks++; if (SplitCount !== 32'd1) begin failures++; $display("FAIL ssw_count actual=%0d required=1", SplitCount); end
   endtask

   task automatic test_split_store_half();
      @(negedge clk); drive(1, 1, 2'b01, 32'h33, 32'h0000BEEF); #1;
      checks++; if (WE !== 4'b0001) begin failures++; $display("FAIL ssh_we0 actual=%b required=0001", WE); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL ssh_stall0 actual=%b required=1", StallM); end
      @(negedge clk); #1;
      checks++; if (A !== 32'h34) begin failures++; $display("FAIL ssh_a1 actual=%h required=00000034", A); end
      checks++; if (WD !== 32'hBE) begin failures++; $display("FAIL ssh_wd1 actual=%h required=000000be", WD); end
      checks++; if (WE !== 4'b0001) begin failures++; $display("FAIL ssh_we1 actual=%b required=0001", WE); end
      @(negedge clk); drive(0, 0, 2'b00, 32'h0, 32'h0); #1;
      checks++; if (mem[12] !== 32'hEF000000) begin failures++; $display("FAIL ssh_word30 actual=%h required=ef000000", mem[12]); end
      checks++; if (mem[13] !== 32'h000000BE) begin failures++; $display("FAIL ssh_word34 actual=%h required=000000be", mem[13]); end
      checks++; if (mem[11] !== 32'h0 || mem[14] !== 32'h0) begin failures++; $display("FAIL ssh_neighbours actual=%h/%h required=0/0", mem[11], mem[14]); end
      checks++; if (SplitCount !== 32'd2) begin failures++; $display("FAIL ssh_count actual=%0d required=2", SplitCount); end
   endtask

   task automatic test_back_to_back();
      poke(6'd8, 32'h44332211);
      poke(6'd9, 32'h88776655);
      @(negedge clk); drive(1, 0, 2'b10, 32'h22, 32'h0); #1;
      checks++; if (BubbleW !== 1'b1) begin failures++; $display("FAIL lw_bubble0 actual=%b required=1", BubbleW); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL lw_stall0 actual=%b required=1", StallM); end
      checks++; if (WE !== 4'b0000) begin failures++; $display("FAIL lw_we0 actual=%b required=0000", WE); end
      @(negedge clk); #1;
      checks++; if (A !== 32'h24) begin failures++; $display("FAIL lw_a1 actual=%h required=00000024", A); end
      checks++; if (BubbleW !== 1'b0 || StallM !== 1'b0) begin failures++; $display("FAIL lw_hold1 actual=%b%b required=00", BubbleW, StallM); end
      @(negedge clk); drive(1, 0, 2'b01, 32'h23, 32'h0); #1;
      checks++; if (LoadDataW !== 32'h66554433) begin failures++; $display("FAIL lw_merge actual=%h required=66554433", LoadDataW); end
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL b2b_stall actual=%b required=1", StallM); end
      @(negedge clk); #1;
      checks++; if (A !== 32'h24) begin failures++; $display("FAIL lh_a1 actual=%h required=00000024", A); end
      @(negedge clk); drive(0, 0, 2'b00, 32'h23, 32'h0); #1;
      checks++; if (LoadDataW !== 32'h00005544) begin failures++; $display("FAIL lh_merge actual=%h required=00005544", LoadDataW); end
      checks++; if (SplitCount !== 32'd4) begin failures++; $display("FAIL lh_count actual=%0d required=4", SplitCount); end
      @(negedge clk); #1;
      checks++; if (LoadDataW !== 32'h44332211) begin failures++; $display("FAIL post_merge_rd actual=%h required=44332211", LoadDataW); end
   endtask

   task automatic test_no_split();
      @(negedge clk); req0 = 1'b1; wr0 = 1'b0; size0 = 2'b10; addr0 = 32'h01; data0 = 32'h0; #1;
      checks++; if (mis0 !== 1'b1) begin failures++; $display("FAIL ns_lw_misalign actual=%b required=1", mis0); end
      checks++; if (we0 !== 4'b0000) begin failures++; $display("FAIL ns_lw_we actual=%b required=0000", we0); end
      checks++; if (stall0 !== 1'b0 || bub0 !== 1'b0) begin failures++; $display("FAIL ns_lw_stall actual=%b%b required=00", stall0, bub0); end
      @(negedge clk); wr0 = 1'b1; data0 = 32'hCAFEF00D; #1;
      checks++; if (we0 !== 4'b0000) begin failures++; $display("FAIL ns_sw_we actual=%b required=0000", we0); end
      checks++; if (a0 !== 32'h01) begin failures++; $display("FAIL ns_sw_addr actual=%h required=00000001", a0); end
      @(negedge clk); size0 = 2'b01; addr0 = 32'h01; #1;
      checks++; if (mis0 !== 1'b0 || we0 !== 4'b0011) begin failures++; $display("FAIL ns_sh_ok actual=%b/%b required=0/0011", mis0, we0); end
      @(negedge clk); size0 = 2'b11; addr0 = 32'h02; wr0 = 1'b0; #1;
      checks++; if (mis0 !== 1'b1) begin failures++; $display("FAIL ns_size11 actual=%b required=1", mis0); end
      @(negedge clk); req0 = 1'b0; #1;
      checks++; if (mis0 !== 1'b0) begin failures++; $display("FAIL ns_noreq actual=%b required=0", mis0); end
      checks++; if (cnt0 !== 32'd0) begin failures++; $display("FAIL ns_count actual=%0d required=0", cnt0); end
   endtask

   task automatic test_reset_mid_split();
      clear_mem();
      @(negedge clk); drive(1, 1, 2'b10, 32'h21, 32'h11223344); #1;
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL mrst_stall0 actual=%b required=1", StallM); end
      @(negedge clk); rst_n = 1'b0; #1;
      checks++; if (WE !== 4'b0000) begin failures++; $display("FAIL mrst_we actual=%b required=0000", WE); end
      checks++; if (A !== 32'h21) begin failures++; $display("FAIL mrst_addr actual=%h required=00000021", A); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL mrst_stall actual=%b required=0", StallM); end
      @(negedge clk); rst_n = 1'b1; drive(0, 0, 2'b00, 32'h0, 32'h0); #1;
      checks++; if (mem[9] !== 32'h0) begin failures++; $display("FAIL mrst_word24 actual=%h required=00000000", mem[9]); end
      checks++; if (mem[8] !== 32'h22334400) begin failures++; $display("FAIL mrst_word20 actual=%h required=22334400", mem[8]); end
      checks++; if (SplitCount !== 32'd0) begin failures++; $display("FAIL mrst_count actual=%0d required=0", SplitCount); end
      @(negedge clk); drive(1, 1, 2'b10, 32'h10, 32'h01020304); #1;
      checks++; if (StallM !== 1'b0 || WE !== 4'b1111 || A !== 32'h10) begin failures++; $display("FAIL mrst_next actual=%b/%b/%h required=0/1111/00000010", StallM, WE, A); end
      @(negedge clk); drive(0, 0, 2'b00, 32'h0, 32'h0); #1;
      checks++; if (mem[4] !== 32'h01020304) begin failures++; $display("FAIL mrst_word10 actual=%h required=01020304", mem[4]); end
   endtask

   initial begin
      drive(0, 0, 2'b00, 32'h0, 32'h0);
      req0 = 1'b0; wr0 = 1'b0; size0 = 2'b00; addr0 = 32'h0; data0 = 32'h0;
      test_reset();
      test_aligned();
      test_split_store_word();
      test_split_store_half();
      test_back_to_back();
      test_no_split();
      test_reset_mid_split();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_split_unit.md
Name: mem_split_unit

Overview:
- Sits in the MEM stage, directly upstream of the write-back segment register and its data RAM port A. It drives that port's A/WD/WE inputs and post-processes its RD output.
- Aligned accesses pass through with zero added latency.
- Halfword/word accesses that cross a 32-bit word boundary are split into two sequential RAM accesses. The block stalls the pipeline for one cycle and merges the two load halves before DataExt.

Parameters:
- SPLIT_EN, 1: 1 = split boundary-crossing accesses; 0 = never split, raise MisalignExcM instead and suppress the access.
- CNT_W, 32: width of the split-event performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- MemReqM  in  1  MEM-stage instruction is a load or store
- MemWriteM  in  1  1 = store, 0 = load
- SizeM  in  2  00 byte, 01 half, 10 word; 11 is treated as a word
- AddrM  in  32  byte address
- StoreDataM  in  32  store data, right-aligned
- A  out  32  to RAM address input
- WD  out  32  to RAM write data (right-aligned; the RAM side shifts by A[1:0])
- WE  out  4  to RAM write enable: 0001, 0011, 0111 or 1111, right-aligned
- RD  in  32  RAM read data, after the segment register's stall/clear handling
- LoadDataW  out  32  to DataExt: RD, or the merged split-load word
- StallM  out  1  holds the IF..MEM segment registers
- BubbleW  out  1  clear for the write-back segment register
- MisalignExcM  out  1  boundary crossing while SPLIT_EN=0
- SplitCount  out  CNT_W  number of splits issued

Behaviour:
- Crossing condition: SizeM=01 and AddrM[1:0]=11; or SizeM=1x and AddrM[1:0]!=00. Byte accesses never cross.
- Let o = AddrM[1:0] and n = bytes (2 or 4). First part k = 4-o bytes; second part m = n-k bytes.
- State machine has two states, IDLE and SECOND. Reset state is IDLE.
- IDLE, no crossing (or MemReqM=0):
  - A=AddrM; WD=StoreDataM; WE = MemWriteM&MemReqM ? (byte 0001 / half 0011 / word 1111) : 0000.
  - StallM=0, BubbleW=0.
- IDLE, crossing, SPLIT_EN=1:
  - First access: A=AddrM; WD=StoreDataM; WE = store ? lower k bits set : 0000 (k=3 gives 0111).
  - StallM=1, BubbleW=1.
  - Latch StoreDataM, AddrM, m and MemWriteM. Next state is SECOND.
- SECOND:
  - Second access: A = {latched addr[31:2]+1, 2'b00}; WD = latched data >> 8k; WE = store ? lower m bits set : 0000.
  - StallM=0, BubbleW=0.
  - Load: capture LoHold = RD >> 8o (the first word's data is valid this cycle) and record merge-pending with k.
  - SplitCount increments; it wraps modulo 2^CNT_W. Next state is IDLE unconditionally.
- Merge, the cycle after SECOND, load only:
  - LoadDataW = (RD << 8k) | LoHold, with bytes at index n and above forced to 0.
  - Merge-pending then clears.
  - The second access address is aligned, so LoadedBytesSelect=0 downstream and DataExt extends from bit 0.
- All other cycles: LoadDataW = RD.
- SPLIT_EN=0 with crossing:
  - MisalignExcM=1 combinationally; WE=0000; no stall; the state machine stays in IDLE.
- A new request in the merge cycle is legal; merge applies only to LoadDataW of the completing load.
- StallM is asserted only in the first-access cycle, so a back-to-back crossing request in the merge cycle starts a new split in that cycle.
- Reset (asynchronous, anytime, including mid-split):
  - State=IDLE; merge-pending=0; LoHold=0; latches=0; SplitCount=0.
  - During reset A=AddrM, WE=0000, StallM=0, BubbleW=0, MisalignExcM=0.
  - An interrupted split is abandoned with no second write.

Test Plan:
- Aligned sw, AddrM=0x10, data 0xAABBCCDD -> one cycle, A=0x10, WE=1111, StallM=0; readback of word 0x10 = 0xAABBCCDD.
- Word store AddrM=0x21, data 0x11223344, memory pre-zeroed -> cycle0 WE=0111, A=0x21, StallM=1; cycle1 A=0x24, WE=0001, WD=0x11; word 0x20=0x22334400, word 0x24=0x00000011; SplitCount=1.
- Halfword store AddrM=0x33, data 0xBEEF -> word 0x30 byte3=0xEF, word 0x34 byte0=0xBE; words pre-zeroed elsewhere unchanged.
- Load word AddrM=0x22, memory 0x20=0x44332211, 0x24=0x88776655 -> BubbleW pulses in cycle0, merge cycle LoadDataW=0x66554433; load half AddrM=0x23 -> LoadDataW=0x00005544.
- SPLIT_EN=0, lw AddrM=0x01 -> MisalignExcM=1, WE=0000, no stall, SplitCount unchanged.
- Assert rst_n=0 during SECOND of a split store to 0x21 -> word 0x24 not written, state IDLE, SplitCount=0; next aligned access completes normally.
